keypad_scanner: RTL and testbench

Input-side counterpart of the multiplexed hex display. It drives the column strobes of a 4x4 matrix keypad one at a time and samples the row lines, the same way the display time-multiplexes its anodes. It debounces the result and accepts only single-key presses. Accepted hex digits are shifted into a 16-bit data word that can feed the display's data bus directly.

---
 rtl/keypad_scanner.sv | 129 ++++++++++++
 tb/tb_keypad_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces whole-frame snapshots,
// accepts single-key presses and shifts accepted hex digits into a 16-bit entry word.
module keypad_scanner #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] data
);

    localparam logic [3:0] DebCnt = 4'(DEBOUNCE);

    typedef enum logic {StIdle, StHeld} state_t;

    state_t           state;
    logic [3:0]       rows_s1, rows_s2;
    logic [DIV_W-1:0] presc;
    logic [1:0]       col;
    logic [15:0]      snap, prev_snap, snap_new;
    logic [3:0]       stable_cnt, cnt_next;
    logic [3:0]       code;
    logic             tick, single;

    function automatic logic [3:0] keymap(input logic [3:0] idx);
        logic [3:0] c;
        unique case (idx)
            4'd0:  c = 4'h1;
            4'd1:  c = 4'h2;
            4'd2:  c = 4'h3;
            4'd3:  c = 4'hA;
            4'd4:  c = 4'h4;
            4'd5:  c = 4'h5;
            4'd6:  c = 4'h6;
            4'd7:  c = 4'hB;
            4'd8:  c = 4'h7;
            4'd9:  c = 4'h8;
            4'd10: c = 4'h9;
            4'd11: c = 4'hC;
            4'd12: c = 4'hE;
            4'd13: c = 4'h0;
            4'd14: c = 4'hF;
            default: c = 4'hD;
        endcase
        return c;
    endfunction

    assign tick = &presc;
    assign cols = ~(4'b0001 << col);

    // Snapshot including the rows sampled on this tick; bit index is {row, col}.
    always_comb begin
        snap_new = snap;
        for (int unsigned r = 0; r < 4; r++) begin
            snap_new[{2'(r), col}] = rows_s2[r];
        end
    end

    always_comb begin
        cnt_next = 4'd1;
        if (snap_new == prev_snap) begin
            cnt_next = (stable_cnt >= DebCnt) ? DebCnt : stable_cnt + 4'd1;
        end
    end

    always_comb begin
        single = ($countones(snap_new) == 1);
        code   = 4'h0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_new[i]) begin
                code = keymap(4'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1    <= 4'h0;
            rows_s2    <= 4'h0;
            presc      <= '0;
            col        <= 2'd0;
            snap       <= 16'h0000;
            prev_snap  <= 16'h0000;
            stable_cnt <= 4'd0;
            state      <= StIdle;
            key        <= 4'h0;
            key_valid  <= 1'b0;
            key_down   <= 1'b0;
            data       <= 16'h0000;
        end else begin
            rows_s1   <= ~rows;
            rows_s2   <= rows_s1;
            presc     <= presc + 1'b1;
            key_valid <= 1'b0;
            if (tick) begin
                snap <= snap_new;
                col  <= col + 2'd1;
                if (col == 2'd3) begin
                    prev_snap  <= snap_new;
                    stable_cnt <= cnt_next;
                    unique case (state)
                        StIdle: begin
                            if (cnt_next == DebCnt && single) begin
                                key       <= code;
                                key_valid <= 1'b1;
                                data      <= {data[11:0], code};
                                key_down  <= 1'b1;
                                state     <= StHeld;
                            end
                        end
                        StHeld: begin
                            if (cnt_next == DebCnt && snap_new == 16'h0000) begin
                                key_down <= 1'b0;
                                state    <= StIdle;
                            end
                        end
                        default: state <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model plus a scoreboard of expected
// {key, data} pairs checked on every key_valid pulse.
module tb_keypad_scanner;

    localparam int F = 32;  // frame length in cycles for DIV_W=3

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;
    logic [15:0] data;

    logic [15:0] pressed = 16'h0000;  // bit r*4+c closes row r to column c
    logic [15:0] data_m  = 16'h0000;
    logic [19:0] exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    keypad_scanner #(
        .DIV_W    (3),
        .DEBOUNCE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down),
        .data      (data)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4'(r * 4 + c)] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] code_of(input int r, input int c);
        logic [15:0] row_codes;
        case (r)
            0:       row_codes = 16'h123A;
            1:       row_codes = 16'h456B;
            2:       row_codes = 16'h789C;
            default: row_codes = 16'hE0FD;
        endcase
        return row_codes[(3 - c) * 4 +: 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n cycles, scoring every key_valid pulse against the queue.
    task automatic step(input int n);
        logic [19:0] e;
        repeat (n) begin
            @(negedge clk);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_pulse", 32'(key_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_key", 32'(key), 32'(e[19:16]));
                    check("pulse_data", 32'(data), 32'(e[15:0]));
                    check("pulse_key_down", 32'(key_down), 32'd1);
                end
            end
        end
    endtask

    task automatic press_key(input int r, input int c);
        data_m = {data_m[11:0], code_of(r, c)};
        exp_q.push_back({code_of(r, c), data_m});
        pressed[4'(r * 4 + c)] = 1'b1;
    endtask

    task automatic tap(input int r, input int c);
        press_key(r, c);
        step(4 * F);
        pressed = 16'h0000;
        step(3 * F);
    endtask

    task automatic check_reset_state();
        check("rst_cols", 32'(cols), 32'hE);
        check("rst_key", 32'(key), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_down", 32'(key_down), 32'h0);
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] nxt;
        int         cnt;

        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Scan order and dwell with no keys pressed.
        cur = 4'b1110;
        for (int s = 0; s < 4; s++) begin
            nxt = {cur[2:0], cur[3]};
            cnt = 0;
            while (cols == cur && cnt < 20) begin
                step(1);
                cnt++;
            end
            check("scan_dwell", 32'(cnt), 32'd8);
            check("scan_next", 32'(cols), 32'(nxt));
            check("scan_one_low", 32'($countones(~cols)), 32'd1);
            cur = nxt;
        end

        // Single press of '5'.
        press_key(1, 1);
        step(4 * F);
        check("held_key_down", 32'(key_down), 32'd1);
        pressed = 16'h0000;
        step(3 * F);
        check("release_key_down", 32'(key_down), 32'd0);
        check("pending_single", 32'(exp_q.size()), 32'd0);

        // Digit entry and rollover.
        tap(0, 0);
        tap(0, 1);
        tap(0, 2);
        tap(0, 3);
        check("entry_data", 32'(data), 32'h123A);
        tap(3, 2);
        check("rollover_data", 32'(data), 32'h23AF);
        check("rollover_key", 32'(key), 32'hF);
        check("pending_entry", 32'(exp_q.size()), 32'd0);

        // Bounce on '7': toggled once per frame so no two consecutive snapshots match
        // (a half-frame toggle would alias with the single per-frame sample of column 0).
        for (int i = 0; i < 12; i++) begin
            pressed[8] = ~pressed[8];
            step(F);
        end
        pressed = 16'h0000;
        step(3 * F);
        check("bounce_data", 32'(data), 32'h23AF);
        check("pending_bounce", 32'(exp_q.size()), 32'd0);

        // Two keys together are never accepted.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        step(5 * F);
        pressed = 16'h0000;
        step(3 * F);
        check("multi_data", 32'(data), 32'h23AF);
        check("multi_key_down", 32'(key_down), 32'd0);

        // '8' held, then '9' added: no event until both release.
        press_key(2, 1);
        step(4 * F);
        check("eight_key_down", 32'(key_down), 32'd1);
        pressed[10] = 1'b1;
        step(4 * F);
        check("eight_nine_data", 32'(data), 32'h3AF8);
        check("eight_nine_key", 32'(key), 32'h8);
        pressed = 16'h0000;
        step(3 * F);
        check("both_release_key_down", 32'(key_down), 32'd0);
        check("pending_multi", 32'(exp_q.size()), 32'd0);
        tap(2, 2);
        check("fresh_nine_data", 32'(data), 32'hAF89);
        check("fresh_nine_key", 32'(key), 32'h9);

        // Reset while '5' is held mid-scan; the held key is re-accepted afterwards.
        press_key(1, 1);
        step(4 * F);
        cnt = 0;
        while (cols == 4'b1110 && cnt < 40) begin
            step(1);
            cnt++;
        end
        rst = 1'b1;
        #1;
        check_reset_state();
        data_m = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        data_m = {data_m[11:0], code_of(1, 1)};
        exp_q.push_back({code_of(1, 1), data_m});
        step(4 * F);
        check("reaccept_key_down", 32'(key_down), 32'd1);
        check("reaccept_data", 32'(data), 32'h0005);
        pressed = 16'h0000;
        step(3 * F);
        check("reaccept_release", 32'(key_down), 32'd0);
        check("pending_final", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
